// File: rtl/alu_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_sequencer_if
// Command / response bundle of the ALU sequencer.
//   cmd_valid/cmd_ready : command handshake (cmd_op, cmd_a, cmd_b, cmd_cnt)
//   rsp_valid/rsp_ready : response handshake (rsp_result, rsp_zero)
// master : the side that issues commands and consumes responses
// slave  : the sequencer
// ---------------------------------------------------------------------------
interface alu_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [4:0]       cmd_cnt;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_cnt, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_zero
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_cnt, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_zero
    );
endinterface

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
// Sequences one command at a time through an external combinational ALU.
// Non-shift ops take a single ALU pass; shl1/shr1 ops are repeated cmd_cnt
// times, feeding the ALU result back into the A operand between passes.
// Ports:
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   bus (slave)     : command / response handshakes
//   alu_select      : ALU opcode, 000 whenever no pass is executing
//   alu_a, alu_b    : registered ALU operands
//   alu_y, alu_zero : combinational ALU result and zero flag
//   ops_done        : wrapping count of completed response handshakes
// ---------------------------------------------------------------------------
module alu_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    alu_sequencer_if.slave    bus,
    output logic [2:0]        alu_select,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    input  logic [WIDTH-1:0]  alu_y,
    input  logic              alu_zero,
    output logic [15:0]       ops_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [2:0]       op_r;
    logic [4:0]       cnt_r;
    logic [WIDTH-1:0] result_r;
    logic             zero_r;

    function automatic logic is_shift(input logic [2:0] op);
        return (op == 3'b101) || (op == 3'b110);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            op_r       <= 3'd0;
            cnt_r      <= 5'd0;
            alu_select <= 3'd0;
            alu_a      <= '0;
            alu_b      <= '0;
            result_r   <= '0;
            zero_r     <= 1'b0;
            ops_done   <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        op_r  <= bus.cmd_op;
                        alu_a <= bus.cmd_a;
                        alu_b <= bus.cmd_b;
                        cnt_r <= bus.cmd_cnt;
                        // A zero-pass shift is just the operand itself.
                        if (is_shift(bus.cmd_op) && (bus.cmd_cnt == 5'd0)) begin
                            result_r <= bus.cmd_a;
                            zero_r   <= (bus.cmd_a == '0);
                            state    <= DONE;
                        end else begin
                            alu_select <= bus.cmd_op;
                            state      <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    // Shift passes chain through the A register.
                    if (is_shift(op_r)) begin
                        alu_a <= alu_y;
                        cnt_r <= cnt_r - 5'd1;
                    end
                    if (!is_shift(op_r) || (cnt_r == 5'd1)) begin
                        result_r   <= alu_y;
                        zero_r     <= alu_zero;
                        alu_select <= 3'd0;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        ops_done <= ops_done + 16'd1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready  = (state == IDLE);
    assign bus.rsp_valid  = (state == DONE);
    assign bus.rsp_result = result_r;
    assign bus.rsp_zero   = zero_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_sequencer
// Bench for alu_sequencer: provides the combinational ALU, a transaction-level
// model of the sequencer, a per-cycle compare process, directed scenarios with
// literal expectations, and a randomized phase.
// ---------------------------------------------------------------------------
module tb_alu_sequencer;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    alu_select;
    logic [W-1:0]  alu_a, alu_b, alu_y;
    logic          alu_zero;
    logic [15:0]   ops_done;

    int n_checks = 0;
    int n_errors = 0;
    logic mon_en = 1'b0;

    always #5 clk = ~clk;

    alu_sequencer_if #(.WIDTH(W)) bus ();

    alu_sequencer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .alu_select (alu_select),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_y      (alu_y),
        .alu_zero   (alu_zero),
        .ops_done   (ops_done)
    );

    function automatic logic [W-1:0] alu_fn(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            3'd0:    return '0;
            3'd1:    return a + b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a << 1;
            3'd6:    return a >> 1;
            default: return ~(a ^ b);
        endcase
    endfunction

    function automatic logic is_sh(input logic [2:0] op);
        return (op == 3'd5) || (op == 3'd6);
    endfunction

    // Whole-shift result after n single-bit passes.
    function automatic logic [W-1:0] shifted(input logic [2:0] op, input logic [W-1:0] a, input int n);
        return (op == 3'd5) ? (a << n) : (a >> n);
    endfunction

    always_comb begin
        alu_y    = alu_fn(alu_select, alu_a, alu_b);
        alu_zero = (alu_y == '0);
    end

    // ---------------- transaction-level model ----------------
    int           m_phase;   // 0 idle, 1 executing, 2 result waiting
    int           m_left;
    int           m_k;
    logic [2:0]   m_op;
    logic [4:0]   m_cnt;
    logic [W-1:0] m_a0, m_alu_a, m_alu_b, m_res;
    logic         m_zero;
    logic [15:0]  m_ops;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0; m_op = 3'd0; m_alu_a = '0; m_alu_b = '0;
            m_res = '0; m_zero = 1'b0; m_ops = 16'd0;
        end else begin
            case (m_phase)
                0: if (bus.cmd_valid) begin
                    m_op = bus.cmd_op; m_a0 = bus.cmd_a; m_cnt = bus.cmd_cnt;
                    m_alu_a = bus.cmd_a; m_alu_b = bus.cmd_b;
                    if (is_sh(m_op) && m_cnt == 5'd0) begin
                        m_res = m_a0; m_zero = (m_a0 == '0); m_phase = 2;
                    end else begin
                        m_phase = 1; m_k = 0;
                        m_left = is_sh(m_op) ? int'(m_cnt) : 1;
                    end
                end
                1: begin
                    m_left--;
                    if (is_sh(m_op)) begin
                        m_k++;
                        m_alu_a = shifted(m_op, m_a0, m_k);
                    end
                    if (m_left == 0) begin
                        m_res  = is_sh(m_op) ? shifted(m_op, m_a0, int'(m_cnt)) : alu_fn(m_op, m_a0, m_alu_b);
                        m_zero = (m_res == '0);
                        m_phase = 2;
                    end
                end
                default: if (bus.rsp_ready) begin
                    m_ops++; m_phase = 0;
                end
            endcase
        end
    end

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            chk("mon_cmd_ready", W'(bus.cmd_ready), W'(m_phase == 0));
            chk("mon_rsp_valid", W'(bus.rsp_valid), W'(m_phase == 2));
            chk("mon_alu_select", W'(alu_select), W'((m_phase == 1) ? m_op : 3'd0));
            chk("mon_alu_a", alu_a, m_alu_a);
            chk("mon_alu_b", alu_b, m_alu_b);
            chk("mon_rsp_result", bus.rsp_result, m_res);
            chk("mon_rsp_zero", W'(bus.rsp_zero), W'(m_zero));
            chk("mon_ops_done", W'(ops_done), W'(m_ops));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic scramble();
        bus.cmd_op  = 3'($urandom_range(0, 7));
        bus.cmd_a   = $urandom;
        bus.cmd_b   = $urandom;
        bus.cmd_cnt = 5'($urandom_range(0, 31));
    endtask

    // Issue one command, measure latency and EXEC passes, hold the response
    // for 'hold' cycles, then complete the handshake.
    task automatic do_cmd(input string nm, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [4:0] cnt, input int hold,
                          input logic [W-1:0] exp_res, input logic exp_zero,
                          input int exp_lat, input int exp_exec);
        int w = 0;
        int lat;
        int nexec = 0;
        while (!bus.cmd_ready && w < 50) begin tick(); w++; end
        chk({nm, "_ready_wait"}, W'(bus.cmd_ready), W'(1'b1));
        bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_a = a; bus.cmd_b = b; bus.cmd_cnt = cnt;
        tick();
        // Keep presenting junk commands while busy; they must be ignored.
        scramble();
        lat = 1;
        while (!bus.rsp_valid && lat < 80) begin
            if (alu_select == op) nexec++;
            tick(); scramble(); lat++;
        end
        chk({nm, "_latency"}, W'(lat), W'(exp_lat));
        chk({nm, "_exec_passes"}, W'(nexec), W'(exp_exec));
        chk({nm, "_result"}, bus.rsp_result, exp_res);
        chk({nm, "_zero"}, W'(bus.rsp_zero), W'(exp_zero));
        for (int i = 0; i < hold; i++) begin
            tick(); scramble();
            chk({nm, "_held_result"}, bus.rsp_result, exp_res);
            chk({nm, "_held_cmd_ready"}, W'(bus.cmd_ready), W'(1'b0));
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0; bus.cmd_valid = 1'b0;
        chk({nm, "_back_idle"}, W'(bus.cmd_ready), W'(1'b1));
        chk({nm, "_rsp_dropped"}, W'(bus.rsp_valid), W'(1'b0));
    endtask

    initial begin
        int seen;
        rst = 1'b1; bus.cmd_valid = 1'b0; bus.rsp_ready = 1'b0;
        bus.cmd_op = 3'd0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_cnt = 5'd0;
        repeat (3) tick();
        rst = 1'b0;
        mon_en = 1'b1;
        chk("reset_cmd_ready", W'(bus.cmd_ready), W'(1'b1));
        chk("reset_rsp_valid", W'(bus.rsp_valid), W'(1'b0));
        chk("reset_ops_done", W'(ops_done), 32'h0);
        chk("reset_alu_a", alu_a, 32'h0);

        do_cmd("add_wrap", 3'd1, 32'hFFFF_FFFF, 32'h1, 5'd0, 0, 32'h0, 1'b1, 2, 1);
        chk("add_ops_done", W'(ops_done), 32'h1);
        do_cmd("shl4", 3'd5, 32'h1, 32'h0, 5'd4, 0, 32'h10, 1'b0, 5, 4);
        do_cmd("xor_bp", 3'd4, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 5'd0, 3, 32'h5A5A_5A5A, 1'b0, 2, 1);
        do_cmd("shr0", 3'd6, 32'h0, 32'h0, 5'd0, 0, 32'h0, 1'b1, 1, 0);
        do_cmd("zero_op", 3'd0, 32'h1234, 32'h5678, 5'd9, 1, 32'h0, 1'b1, 2, 1);
        do_cmd("xnor", 3'd7, 32'hF0F0_0000, 32'h0F0F_0000, 5'd3, 0, 32'h0000_FFFF, 1'b0, 2, 1);
        do_cmd("shr31", 3'd6, 32'h8000_0000, 32'h0, 5'd31, 0, 32'h1, 1'b0, 32, 31);
        chk("ops_done_7", W'(ops_done), 32'h7);

        // Reset during a long shift: the command vanishes without a response.
        bus.cmd_valid = 1'b1; bus.cmd_op = 3'd6; bus.cmd_a = 32'h8000_0000; bus.cmd_b = '0; bus.cmd_cnt = 5'd20;
        tick();
        bus.cmd_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_cmd_ready", W'(bus.cmd_ready), W'(1'b1));
        chk("rst_mid_rsp_valid", W'(bus.rsp_valid), W'(1'b0));
        chk("rst_mid_ops_done", W'(ops_done), 32'h0);
        chk("rst_mid_alu_select", W'(alu_select), 32'h0);
        chk("rst_mid_result", bus.rsp_result, 32'h0);
        bus.rsp_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.rsp_valid) seen++;
        end
        bus.rsp_ready = 1'b0;
        chk("rst_mid_no_response", W'(seen), 32'h0);

        // Randomized traffic with occasional resets, checked by the model.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            bus.cmd_valid = 1'($urandom_range(0, 1));
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            bus.cmd_op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       bus.cmd_a = '0;
                1:       bus.cmd_a = 32'hFFFF_FFFF;
                default: bus.cmd_a = $urandom;
            endcase
            bus.cmd_b = ($urandom_range(0, 3) == 0) ? ~bus.cmd_a : $urandom;
            bus.cmd_cnt = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
            tick();
        end
        rst = 1'b1; bus.cmd_valid = 1'b0; bus.rsp_ready = 1'b0;
        tick();
        rst = 1'b0;

        // Counter wrap: preload near the top, then two more handshakes.
        force dut.ops_done = 16'hFFFE;
        m_ops = 16'hFFFE;
        #1;
        release dut.ops_done;
        do_cmd("wrap_a", 3'd3, 32'h1, 32'h2, 5'd0, 0, 32'h3, 1'b0, 2, 1);
        chk("wrap_ffff", W'(ops_done), 32'hFFFF);
        do_cmd("wrap_b", 3'd2, 32'hF0, 32'h0F, 5'd0, 0, 32'h0, 1'b1, 2, 1);
        chk("wrap_zero", W'(ops_done), 32'h0);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: WIDTH, default 32, data width of operands, ALU ports and result.
REQ-002 Clocking: one clock; reset is synchronous and active-high. The clock port is clk and the reset port is rst.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 cmd_valid  input  1  command present.
REQ-006 cmd_ready  output  1  sequencer can accept a command.
REQ-007 cmd_op  input  3  ALU operation: 000 zero, 001 add, 010 and, 011 or, 100 xor, 101 shl1, 110 shr1, 111 xnor.
REQ-008 cmd_a, cmd_b  input  WIDTH  operands.
REQ-009 cmd_cnt  input  5  pass count for 101/110; ignored for all other ops.
REQ-010 alu_select  output  3  drives the ALU select input.
REQ-011 alu_a, alu_b  output  WIDTH  drive the ALU operand inputs.
REQ-012 alu_y  input  WIDTH  combinational ALU result.
REQ-013 alu_zero  input  1  ALU zero flag (alu_y == 0).
REQ-014 rsp_valid  output  1  result available.
REQ-015 rsp_ready  input  1  consumer accepts the result.
REQ-016 rsp_result  output  WIDTH  final result.
REQ-017 rsp_zero  output  1  final zero flag.
REQ-018 ops_done  output  16  count of completed response handshakes.

Function
REQ-019 The FSM SHALL have the states IDLE, EXEC and DONE.
REQ-020 cmd_ready SHALL be 1 only in IDLE; rsp_valid SHALL be 1 only in DONE.
REQ-021 Accept: cmd_valid&&cmd_ready at edge T SHALL latch op, a, b and cnt into registers.
 - Shift op with cnt==0: go to DONE, with rsp_result=cmd_a and rsp_zero=(cmd_a==0).
 - Any other command: go to EXEC.
REQ-022 In EXEC, alu_select/alu_a/alu_b SHALL be driven from registers only, never combinationally from cmd_* inputs.
REQ-023 Non-shift op: one EXEC cycle. At its end, capture alu_y/alu_zero into rsp_result/rsp_zero and go to DONE; rsp_valid rises at T+2.
REQ-024 Shift op with cnt=N (1..31): N EXEC cycles.
 - After each cycle, alu_y SHALL be written back into the alu_a register and the remaining count decremented.
 - The last pass captures the result; rsp_valid rises at T+1+N.
REQ-025 Outside EXEC, alu_select SHALL be 000, and alu_a/alu_b SHALL hold their last values.
REQ-026 rsp_result/rsp_zero SHALL stay stable while rsp_valid=1 and rsp_ready=0.
REQ-027 Handshake rsp_valid&&rsp_ready SHALL return the FSM to IDLE and increment ops_done.
 - ops_done wraps 0xFFFF -> 0x0000.
 - A new command cannot be accepted in the same cycle (cmd_ready is low in DONE).
REQ-028 Op 000 SHALL run one EXEC pass, yielding rsp_result=0 and rsp_zero=1.
REQ-029 All arithmetic is modulo 2^WIDTH; carry-out is discarded.
REQ-030 Changes on cmd_* outside an accept edge SHALL have no effect.

Reset
REQ-031 rst=1 at an edge SHALL force, in any state including mid-shift:
 - state=IDLE, cmd_ready=1, rsp_valid=0;
 - rsp_result=0, rsp_zero=0, ops_done=0;
 - alu_select=000, alu_a=0, alu_b=0, internal count=0.
REQ-032 Any in-flight command SHALL be discarded with no response.
REQ-033 rst SHALL take priority over cmd and rsp handshakes in the same cycle.

Verification
REQ-034 ADD: a=0xFFFFFFFF, b=0x1, accepted at T -> rsp_valid=1 at T+2, rsp_result=0x0, rsp_zero=1, ops_done=1 after the handshake.
REQ-035 SHL: op=101, a=0x1, cnt=4 -> alu_select=101 for T+1..T+4, rsp_valid at T+5, rsp_result=0x10, rsp_zero=0.
REQ-036 Backpressure: XOR a=0xA5A5A5A5, b=0xFFFFFFFF, rsp_ready=0 for 3 cycles -> rsp_result=0x5A5A5A5A held stable, cmd_ready=0 throughout; IDLE one cycle after rsp_ready=1.
REQ-037 Zero-count shift: op=110, a=0x0, cnt=0 -> rsp_valid at T+1, rsp_result=0, rsp_zero=1, no EXEC cycle.
REQ-038 Reset mid-op: SHR a=0x80000000, cnt=20, rst at T+5 -> next cycle IDLE, cmd_ready=1, rsp_valid=0, ops_done=0; no response ever emitted.
REQ-039 Wrap: preload 65535 handshakes (or force), then one more -> ops_done=0x0000.
